lsu_axil_master: RTL and testbench
==================================

# lsu_axil_master

AXI-lite master for the load/store unit: turns one core memory request (load or store) into a single AXI-lite read (AR/R) or write (AW/W/B) transaction, then returns the result to the core. It is the initiator that faces the data-side SRAM/bus slave. It supports one outstanding transaction only. All bus-facing outputs are registered or decoded from the state register only, so no combinational path exists from any slave input to any master output.

## Interface
- ADDR_W, 32, address width (`AXI_ADDR_BUS`)
- DATA_W, 32, data width (`AXI_DATA_BUS`); strobe width DATA_W/8 (`AXI_WSTRB_BUS`)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid / req_ready  in / out  1  core request handshake
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata / req_wstrb  in  DATA_W / DATA_W/8  store data and byte enables
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  DATA_W  load data (0 for stores)
- rsp_err  out  1  resp[1] of the returned RRESP or BRESP (SLVERR/DECERR)
- araddr, arvalid / arready  out, out / in  ADDR_W, 1  AR channel
- rdata, rresp, rvalid / rready  in, in, in / out  DATA_W, 2, 1  R channel
- awaddr, awvalid / awready  out, out / in  ADDR_W, 1  AW channel
- wdata, wstrb, wvalid / wready  out, out, out / in  DATA_W, DATA_W/8, 1  W channel
- bresp, bvalid / bready  in, in / out  2, 1  B channel

## Operation
- States: IDLE, AR, R, WR, B, RSP.
- req_ready = (state==IDLE). Accepting a request latches addr, wdata, wstrb, and we.
- IDLE: on req_valid&&req_ready, go to AR if !req_we, else go to WR.
- AR: arvalid=1, araddr=latched addr. On arvalid&&arready, go to R.
- R: rready=1. On rvalid, capture rdata into rsp_rdata and rresp[1] into rsp_err, then go to RSP.
- WR: awvalid=!aw_done and wvalid=!w_done. Each flag sets on its own handshake. AW and W may complete in either order or in the same cycle. When both are done (counting handshakes in the current cycle), clear the flags and go to B.
- B: bready=1. On bvalid, capture bresp[1] into rsp_err, set rsp_rdata=0, then go to RSP.
- RSP: rsp_valid=1, holding rsp_rdata and rsp_err stable. On rsp_ready, go to IDLE.
- araddr, awaddr, wdata, and wstrb hold stable while their valid is high. Once asserted, a valid is never dropped before its handshake.
- rresp/bresp value 2'b00 or 2'b01 gives rsp_err=0. Value 2'b10 or 2'b11 gives rsp_err=1. The transaction still completes normally.
- Unused state encodings go to IDLE.

## Timing
- Reset (rst_n=0 at an edge) sets state=IDLE, all valid/ready outputs to 0 except req_ready, and aw_done=w_done=0. araddr, awaddr, wdata, wstrb, rsp_rdata, and rsp_err reset to 0. req_ready is 1 from the first cycle after the reset edge.
- Reset in any state abandons the transaction. All bus valid/ready outputs are 0 the next cycle, and no rsp_valid is issued.
- Request accepted at edge N: arvalid/awvalid/wvalid rise in cycle N+1.
- Minimum load latency, with zero-wait slave (arready=1, rvalid same cycle as rready): request accepted at edge 0, AR handshake at edge 1, R handshake at edge 2, rsp_valid in cycle 3.
- Minimum store latency: AW and W handshake at edge 1, B at edge 2, rsp_valid in cycle 3.
- Back-to-back: the next req_ready is at the cycle after the rsp handshake.
- Stalls of any length on arready, rvalid, awready, wready, bvalid, or rsp_ready are tolerated. Registers hold their values during stalls.

## Test plan
- Load, zero-wait slave: req_addr=0x8000_0004 with rdata=0x0000_0013, rresp=0. Expect araddr=0x8000_0004 in cycle 1, rsp_valid in cycle 3, rsp_rdata=0x13, rsp_err=0.
- Load against a slave with registered arready and a 2-cycle read wait. Expect arvalid held with stable araddr until arready, rready held until rvalid, and correct data returned.
- Store, addr 0x8000_0100, wdata 0xDEAD_BEEF, wstrb 4'b0011, with three ordering cases: AW accepted 2 cycles before W; W before AW; both in the same cycle. Expect each valid to drop the cycle after its own handshake, bready only after both, and rsp_rdata=0.
- Error responses: rresp=2'b10 on a load and bresp=2'b11 on a store. Expect rsp_err=1 and return to IDLE after rsp_ready.
- Backpressure: rsp_ready low for 4 cycles. Expect rsp_valid/rsp_rdata stable, req_ready=0, and no new AR/AW.
- Reset asserted in R and again in WR after AW only. Expect all valids 0 the cycle after the reset edge, req_ready=1, no rsp_valid, and the next load completing normally.

Source files
------------

// File: rtl/lsu_axil_master.sv
// lsu_axil_master: turns one core load/store into a single AXI-lite read or write transaction.
// Bus valids/readies decode from registered state only, so no slave input reaches a master output.
module lsu_axil_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RSP} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err, r_aw_done, r_w_done;
    logic                w_aw_hs, w_w_hs, w_wr_done, w_unused;

    assign o_req_ready = r_state == S_IDLE;
    assign o_arvalid   = r_state == S_AR;
    assign o_rready    = r_state == S_R;
    assign o_awvalid   = r_state == S_WR && !r_aw_done;
    assign o_wvalid    = r_state == S_WR && !r_w_done;
    assign o_bready    = r_state == S_B;
    assign o_rsp_valid = r_state == S_RSP;
    assign o_araddr    = r_addr;
    assign o_awaddr    = r_addr;
    assign o_wdata     = r_wdata;
    assign o_wstrb     = r_wstrb;
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
    assign w_unused    = ^{i_rresp[0], i_bresp[0]};

    assign w_aw_hs   = o_awvalid && i_awready;
    assign w_w_hs    = o_wvalid && i_wready;
    // a handshake landing this cycle counts towards completion of the write address/data pair
    assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    always_ff @(posedge clk)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_req_valid ? (i_req_we ? S_WR : S_AR) : S_IDLE;
            S_AR:    w_next = i_arready ? S_R : S_AR;
            S_R:     w_next = i_rvalid ? S_RSP : S_R;
            S_WR:    w_next = w_wr_done ? S_B : S_WR;
            S_B:     w_next = i_bvalid ? S_RSP : S_B;
            S_RSP:   w_next = i_rsp_ready ? S_IDLE : S_RSP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_req_valid) begin
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_wstrb <= i_req_wstrb;
            end
            if (r_state == S_R && i_rvalid) begin
                r_rdata <= i_rdata;
                r_err   <= i_rresp[1];
            end
            if (r_state == S_B && i_bvalid) begin
                r_rdata <= '0;
                r_err   <= i_bresp[1];
            end
            if (r_state == S_WR) begin
                r_aw_done <= w_wr_done ? 1'b0 : (r_aw_done || w_aw_hs);
                r_w_done  <= w_wr_done ? 1'b0 : (r_w_done || w_w_hs);
            end
        end
    end
endmodule

// File: tb/tb_lsu_axil_master.sv
// tb_lsu_axil_master: directed and randomized load/store transactions against a scripted AXI-lite slave,
// with expected bus activity and responses computed from the transaction description.
module tb_lsu_axil_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0, i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic [3:0]  i_req_wstrb = '0;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata, o_araddr, o_awaddr, o_wdata;
    logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic        i_arready = 1'b0, i_rvalid = 1'b0, i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = '0, i_bresp = '0;
    logic [3:0]  o_wstrb;
    int          n_vec = 0, n_err = 0;

    lsu_axil_master dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".arvalid"}, o_arvalid, 0);
        chk({tag, ".rready"}, o_rready, 0);
        chk({tag, ".awvalid"}, o_awvalid, 0);
        chk({tag, ".wvalid"}, o_wvalid, 0);
        chk({tag, ".bready"}, o_bready, 0);
        chk({tag, ".rsp_valid"}, o_rsp_valid, 0);
        chk({tag, ".req_ready"}, o_req_ready, 1);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_quiet(tag);
        chk({tag, ".araddr"}, o_araddr, 0);
        chk({tag, ".awaddr"}, o_awaddr, 0);
        chk({tag, ".wdata"}, o_wdata, 0);
        chk({tag, ".wstrb"}, o_wstrb, 0);
        chk({tag, ".rsp_rdata"}, o_rsp_rdata, 0);
        chk({tag, ".rsp_err"}, o_rsp_err, 0);
    endtask

    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        chk("accept.req_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wd;
        i_req_wstrb = ws;
        tick();
        i_req_valid = 1'b0;
        i_req_we    = 1'(~we);
        i_req_addr  = $urandom;
        i_req_wdata = $urandom;
        i_req_wstrb = 4'($urandom);
    endtask

    // d_a/d_b: AR and R waits for a load, AW and W waits for a store; d_c: B wait; d_rsp: rsp_ready wait
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] rd, input logic [1:0] resp, input int d_a, input int d_b,
                       input int d_c, input int d_rsp);
        logic [31:0] exp_rd;
        bit          awd, wdn;
        exp_rd = we ? 32'h0 : rd;
        awd = 0;
        wdn = 0;
        accept(we, addr, wd, ws);
        if (!we) begin
            for (int c = 0; c <= d_a; c++) begin
                chk("ar.arvalid", o_arvalid, 1);
                chk("ar.araddr", o_araddr, addr);
                chk("ar.awvalid", o_awvalid, 0);
                chk("ar.rready", o_rready, 0);
                chk("ar.rsp_valid", o_rsp_valid, 0);
                chk("ar.req_ready", o_req_ready, 0);
                i_arready = (c == d_a);
                tick();
                i_arready = 1'b0;
            end
            for (int c = 0; c <= d_b; c++) begin
                chk("r.arvalid", o_arvalid, 0);
                chk("r.rready", o_rready, 1);
                chk("r.rsp_valid", o_rsp_valid, 0);
                i_rvalid = (c == d_b);
                i_rdata  = i_rvalid ? rd : $urandom;
                i_rresp  = i_rvalid ? resp : 2'($urandom);
                tick();
                i_rvalid = 1'b0;
                i_rdata  = $urandom;
                i_rresp  = 2'($urandom);
            end
        end else begin
            for (int c = 0; !(awd && wdn) && c < 20; c++) begin
                chk("wr.awvalid", o_awvalid, !awd);
                chk("wr.wvalid", o_wvalid, !wdn);
                if (!awd) chk("wr.awaddr", o_awaddr, addr);
                if (!wdn) chk("wr.wdata", o_wdata, wd);
                if (!wdn) chk("wr.wstrb", o_wstrb, ws);
                chk("wr.bready", o_bready, 0);
                chk("wr.arvalid", o_arvalid, 0);
                chk("wr.rsp_valid", o_rsp_valid, 0);
                i_awready = !awd && c >= d_a;
                i_wready  = !wdn && c >= d_b;
                tick();
                awd = awd || i_awready;
                wdn = wdn || i_wready;
                i_awready = 1'b0;
                i_wready  = 1'b0;
            end
            for (int c = 0; c <= d_c; c++) begin
                chk("b.bready", o_bready, 1);
                chk("b.awvalid", o_awvalid, 0);
                chk("b.wvalid", o_wvalid, 0);
                chk("b.rsp_valid", o_rsp_valid, 0);
                i_bvalid = (c == d_c);
                i_bresp  = i_bvalid ? resp : 2'($urandom);
                tick();
                i_bvalid = 1'b0;
                i_bresp  = 2'($urandom);
            end
        end
        for (int c = 0; c <= d_rsp; c++) begin
            chk("rsp.rsp_valid", o_rsp_valid, 1);
            chk("rsp.rsp_rdata", o_rsp_rdata, exp_rd);
            chk("rsp.rsp_err", o_rsp_err, resp[1]);
            chk("rsp.req_ready", o_req_ready, 0);
            chk("rsp.arvalid", o_arvalid, 0);
            chk("rsp.awvalid", o_awvalid, 0);
            chk("rsp.wvalid", o_wvalid, 0);
            i_rsp_ready = (c == d_rsp);
            tick();
            i_rsp_ready = 1'b0;
        end
        chk("done.rsp_valid", o_rsp_valid, 0);
        chk("done.req_ready", o_req_ready, 1);
    endtask

    initial begin
        repeat (2) tick();
        do_reset("reset");
        txn(0, 32'h8000_0004, 32'h0, 4'h0, 32'h0000_0013, 2'b00, 0, 0, 0, 0);
        txn(0, 32'h8000_0040, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b01, 1, 2, 0, 0);
        txn(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 0, 2, 0, 0);
        txn(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 2, 0, 0, 0);
        txn(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 0, 0, 0, 0);
        txn(0, 32'h8000_0008, 32'h0, 4'h0, 32'h1234_5678, 2'b10, 0, 1, 0, 1);
        txn(1, 32'h8000_000C, 32'h5555_AAAA, 4'hF, 32'h0, 2'b11, 1, 1, 2, 0);
        txn(0, 32'h8000_0010, 32'h0, 4'h0, 32'hA5A5_5A5A, 2'b00, 0, 0, 0, 4);
        accept(0, 32'h8000_0020, 32'h0, 4'h0);
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        chk("rst_r.rready", o_rready, 1);
        do_reset("rst_r");
        tick();
        chk_quiet("rst_r.idle");
        txn(0, 32'h8000_0024, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00, 0, 0, 0, 0);
        accept(1, 32'h8000_0028, 32'h1111_2222, 4'hC);
        i_awready = 1'b1;
        tick();
        i_awready = 1'b0;
        chk("rst_wr.awvalid", o_awvalid, 0);
        chk("rst_wr.wvalid", o_wvalid, 1);
        do_reset("rst_wr");
        tick();
        chk_quiet("rst_wr.idle");
        txn(1, 32'h8000_002C, 32'h3333_4444, 4'h5, 32'h0, 2'b00, 1, 0, 0, 0);
        txn(0, 32'h8000_0030, 32'h0, 4'h0, 32'h7777_8888, 2'b00, 0, 0, 0, 0);
        repeat (60) txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, 2'($urandom),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
